// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// One request outstanding at a time; IMemValid returns exactly once per IMemReq.
interface instruction_fetch_stage_if;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemValid;
   logic [31:0] IMemRdata;

   modport master (
      output IMemReq,
      output IMemAddr,
      input  IMemValid,
      input  IMemRdata
   );

   modport slave (
      input  IMemReq,
      input  IMemAddr,
      output IMemValid,
      output IMemRdata
   );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and fills IF/ID.
// Optional FETCH_PERF_COUNT_EN adds FetchCount/StallCount performance counters.
//
// Memory handshake: IMemReq is a one-cycle pulse in ISSUE; IMemAddr stays stable until
// the matching IMemValid, which comes at least one cycle later. IMemValid outside WAIT/DROP
// is ignored. A response is only consumed in WAIT (captured) or DROP (discarded).
module instruction_fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                        Clk,
   input  logic                        Reset,
   instruction_fetch_stage_if.master   imem,
   input  logic                        IDStall,
   input  logic                        Flush,
   input  logic                        BranchTaken,
   input  logic [31:0]                 BranchTarget,
   output logic [31:0]                 Instruction,
   output logic [31:0]                 PCPlus4,
   output logic                        IFValid,
`ifdef FETCH_PERF_COUNT_EN
   output logic [31:0]                 FetchCount,
   output logic [31:0]                 StallCount,
`endif
   output logic [1:0]                  dbg_state
);

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DROP  = 2'd3
   } fetch_state_e;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc4_q, pc4_d;
   logic         valid_q, valid_d;
   logic [31:0]  skid_q, skid_d;

   logic [31:0]  branch_pc;
   logic         unused_target_bits;

   assign branch_pc          = {BranchTarget[31:2], 2'b00};
   assign unused_target_bits = ^BranchTarget[1:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_ISSUE;
         pc_q    <= PC_RESET;
         addr_q  <= PC_RESET;
         instr_q <= NOP_WORD;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         skid_q  <= NOP_WORD;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         skid_q  <= skid_d;
      end
   end

   // The skid entry is full exactly while in HOLD; no separate occupancy flag is kept.
   // In HOLD pc_q has already advanced past the skid word, so it is that word's PC+4.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      skid_d  = skid_q;

      if (!IDStall || Flush) begin
         valid_d = 1'b0;
         instr_d = NOP_WORD;
      end

      case (state_q)
         ST_ISSUE: begin
            addr_d  = pc_q;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem.IMemValid) begin
               pc_d = pc_q + 32'd4;
               if (!valid_q || !IDStall) begin
                  instr_d = imem.IMemRdata;
                  pc4_d   = pc_q + 32'd4;
                  valid_d = 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  skid_d  = imem.IMemRdata;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (!IDStall) begin
               instr_d = skid_q;
               pc4_d   = pc_q;
               valid_d = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_DROP: begin
            if (imem.IMemValid) begin
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_ISSUE;
      endcase

      // A redirect discards everything younger than the branch, including any word
      // arriving this cycle; DROP swallows the response of a request still in flight.
      if (BranchTaken) begin
         pc_d    = branch_pc;
         instr_d = NOP_WORD;
         valid_d = 1'b0;
         pc4_d   = pc4_q;
         skid_d  = skid_q;
         case (state_q)
            ST_ISSUE: state_d = ST_DROP;
            ST_WAIT:  state_d = imem.IMemValid ? ST_ISSUE : ST_DROP;
            ST_HOLD:  state_d = ST_ISSUE;
            ST_DROP:  state_d = imem.IMemValid ? ST_ISSUE : ST_DROP;
            default:  state_d = ST_ISSUE;
         endcase
      end
   end

   assign imem.IMemReq  = (state_q == ST_ISSUE) && !Reset;
   assign imem.IMemAddr = (state_q == ST_ISSUE) ? pc_q : addr_q;
   assign Instruction   = instr_q;
   assign PCPlus4       = pc4_q;
   assign IFValid       = valid_q;
   assign dbg_state     = state_q;

`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Only words taken from memory count; a skid-to-IF/ID move is not a new fetch.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if ((state_q == ST_WAIT) && imem.IMemValid && !BranchTaken) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (IDStall && valid_q) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign StallCount = stall_cnt_q;
`endif

endmodule
